apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
APB completer (slave) holding a bank of 32-bit registers. It answers reads and writes from the team's APB master, for example the read / increment / write-back traffic to 0xDEAD_CAFE. Wait states are programmable, so the master's pready handling can be exercised against real RTL instead of a random bench driver. The block sits on the APB bus as the endpoint for one address window.

Parameters:
- BASE_ADDR, 32'hDEAD_CA00, byte address of register 0. Window is word-aligned.
- NUM_REGS, 64, number of 32-bit registers. Window size is NUM_REGS*4 bytes.
- WAIT_STATES, 2, number of ACCESS cycles with pready_o low before pready_o rises. Range 0..15.
- ID_VALUE, 32'hA5B0_0016, constant returned by register 0, which is read-only.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- psel_i, input, 1, APB select.
- penable_i, input, 1, APB enable (access phase).
- paddr_i, input, 32, byte address.
- pwrite_i, input, 1, 1 = write, 0 = read.
- pwdata_i, input, 32, write data.
- pready_o, output, 1, transfer completes in a cycle where psel_i & penable_i & pready_o.
- prdata_o, output, 32, read data; valid only while pready_o=1 on a read, else 0.
- pslverr_o, output, 1, error response; valid only while pready_o=1, else 0.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE, wait counter=0.
  - All registers 1..NUM_REGS-1 cleared to 0.
  - pready_o=0, prdata_o=0, pslverr_o=0.
  - An in-flight write is dropped.
- Decode:
  - off = paddr_i - BASE_ADDR (32-bit unsigned wrap).
  - idx = off[31:2]; paddr_i[1:0] is ignored.
  - 0xDEAD_CAFE maps to idx 63.
  - hit = paddr_i >= BASE_ADDR && idx < NUM_REGS.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On psel_i & ~penable_i (SETUP), latch addr/pwrite/pwdata, load cnt <= WAIT_STATES, go to ACCESS.
  - penable_i without a preceding SETUP is ignored.
- ACCESS:
  - pready_o = (cnt==0). This is combinational from registered state only; no input-to-output combinational path.
  - While cnt != 0 and psel_i & penable_i, cnt decrements each cycle.
  - WAIT_STATES=0 gives a zero-wait transfer: SETUP at cycle T, pready_o=1 in cycle T+1.
  - On completion (psel_i & penable_i & pready_o), return to IDLE. The next SETUP may arrive in the very next cycle (back-to-back, no idle cycle required).
  - If psel_i drops in ACCESS: abort to IDLE, no register update, pready_o low next cycle.
- Read data:
  - prdata_o = reg[idx] of the latched address while pready_o=1 on a read.
  - Register 0 returns ID_VALUE.
  - A miss returns 0.
- Write commit:
  - Happens on the completion edge only, using latched pwdata.
  - Writes to register 0 or to a miss have no effect.
  - A write followed immediately by a read of the same register returns the new value.
- Address/data changes from the master during ACCESS are ignored, since the latched copies are used.
- Verification checks these as protocol assertions, not as RTL behaviour:
  - paddr/pwrite stable during ACCESS.
  - pready_o never high in IDLE.

Optional Feature:
- APB_SLV_ERR_EN defined:
  - pslverr_o=1 with pready_o on a miss, on a write to register 0, or on any paddr_i[1:0] != 0 when paddr_i >= BASE_ADDR + NUM_REGS*4.
  - Errored writes are not committed.
- APB_SLV_ERR_EN undefined:
  - pslverr_o tied 0.
  - Misses read 0, writes to misses and register 0 are silently dropped.

Test Plan:
1. Reset, then read 0xDEAD_CA00 with WAIT_STATES=2 -> pready_o low for 2 ACCESS cycles, high on the 3rd; prdata_o=32'hA5B0_0016; pslverr_o=0.
2. Write 32'h0000_0007 to 0xDEAD_CAFE, then read 0xDEAD_CAFE, then write back 32'h0000_0008 (master increment flow) -> reads return 7 then 8; reg 63 = 8.
3. WAIT_STATES=0 back-to-back write/read of 0xDEAD_CA04 with value 32'h1234_5678 -> pready_o=1 in the first ACCESS cycle of each; read returns 32'h1234_5678; no idle cycle needed.
4. Read 0xDEAD_CB00 (idx 64, miss) and write 0xDEAD_CA00 -> prdata_o=0; reg 0 still reads ID_VALUE; pslverr_o=1 on both only if APB_SLV_ERR_EN.
5. Assert reset during the ACCESS wait of a write of 32'hFFFF_FFFF to 0xDEAD_CA08 -> pready_o drops immediately; reg 2 reads 0 afterwards.
6. Drop psel_i mid-ACCESS of a write to 0xDEAD_CA0C -> FSM returns to IDLE; reg 3 unchanged (0); the next SETUP is accepted normally.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// apb_regfile_slave
//
// APB completer holding a bank of NUM_REGS 32-bit registers inside one
// word-aligned address window that starts at BASE_ADDR. Register 0 is a
// read-only identification word (ID_VALUE); registers 1..NUM_REGS-1 are
// read/write and clear to zero on reset. Every transfer is stretched by
// WAIT_STATES access cycles with pready_o low, so a master's wait-state
// handling can be exercised against real RTL.
//
// Optional feature (compile-time macro APB_SLV_ERR_EN):
//   defined   - pslverr_o is raised with pready_o on a miss, on a write to
//               register 0, and on any non-word-aligned address at or above
//               the end of the window; errored writes are not committed.
//   undefined - pslverr_o is tied low; misses read as zero and writes to
//               misses or to register 0 are silently dropped.
//
// Ports:
//   clk        in   1   clock, all logic on the rising edge
//   reset      in   1   asynchronous active-high reset
//   psel_i     in   1   APB select
//   penable_i  in   1   APB enable (access phase)
//   paddr_i    in  32   byte address
//   pwrite_i   in   1   1 = write, 0 = read
//   pwdata_i   in  32   write data
//   pready_o   out  1   transfer completes when psel_i & penable_i & pready_o
//   prdata_o   out 32   read data, non-zero only while pready_o on a read
//   pslverr_o  out  1   error response, only while pready_o
//
// Parameters: BASE_ADDR, NUM_REGS (>= 2), WAIT_STATES (0..15), ID_VALUE.
// -----------------------------------------------------------------------------
module apb_regfile_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CA00,
    parameter int          NUM_REGS    = 64,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0016
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o
);

    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
`ifdef APB_SLV_ERR_EN
    localparam logic [31:0] WIN_END  = BASE_ADDR + 32'(NUM_REGS * 4);
`endif

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] idx_q;
    logic             hit_q;
    logic             write_q;
    logic             err_q;
    logic [31:0]      wdata_q;

    // Register 0 is the constant ID word, so storage starts at index 1.
    logic [31:0]      regs [1:NUM_REGS-1];

    logic [31:0]      off;
    logic [29:0]      word_idx;
    logic             setup_hit;
    logic             setup_err;
    logic [1:0]       unused_off;
    logic             complete;
    logic             commit;
    logic [31:0]      rd_word;

    // Address decode of the live bus. Only consumed in the SETUP cycle; the
    // results are latched so later bus changes cannot affect the transfer.
    // Subtraction wraps, so an address below BASE_ADDR yields a huge index
    // and misses naturally; the explicit compare keeps the intent obvious.
    always_comb begin
        off       = paddr_i - BASE_ADDR;
        word_idx  = off[31:2];
        setup_hit = (paddr_i >= BASE_ADDR) && (word_idx < 30'(NUM_REGS));
`ifdef APB_SLV_ERR_EN
        setup_err = !setup_hit
                  || (pwrite_i && (word_idx == 30'd0))
                  || ((paddr_i >= WIN_END) && (paddr_i[1:0] != 2'b00));
`else
        setup_err = 1'b0;
`endif
    end

    // Byte-lane bits of the offset play no part in register selection.
    assign unused_off = off[1:0];

    // Transfer handshake: IDLE waits for SETUP and latches the request,
    // ACCESS counts down wait states while the master holds the enable phase.
    // Dropping psel_i in ACCESS abandons the transfer without side effects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        idx_q   <= word_idx[IDX_W-1:0];
                        hit_q   <= setup_hit;
                        write_q <= pwrite_i;
                        err_q   <= setup_err;
                        wdata_q <= pwdata_i;
                        cnt     <= WAIT_INIT;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel_i) begin
                        state <= IDLE;
                    end else if (penable_i) begin
                        if (cnt == 4'd0) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign complete = (state == ACCESS) && psel_i && penable_i && (cnt == 4'd0);
    assign commit   = complete && write_q && hit_q && !err_q && (idx_q != '0);

    // Register bank: writes land only on the completion edge and use the
    // latched data, so a reset or abort before that edge leaves it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (commit) begin
            regs[idx_q] <= wdata_q;
        end
    end

    // Outputs derive from registered state only, never from the live bus.
    assign rd_word   = (idx_q == '0) ? ID_VALUE : regs[idx_q];
    assign pready_o  = (state == ACCESS) && (cnt == 4'd0);
    assign prdata_o  = (pready_o && !write_q && hit_q) ? rd_word : 32'd0;
    assign pslverr_o = pready_o && err_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_regfile_slave
//
// Drives two copies of apb_regfile_slave: unit 0 with two wait states and
// unit 1 with zero wait states. A register-array model predicts every output
// cycle by cycle from the transfer being driven; a compare process checks all
// outputs of both units on every falling edge. Literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_apb_regfile_slave;

    localparam logic [31:0] BASE   = 32'hDEAD_CA00;
    localparam int          NREGS  = 64;
    localparam logic [31:0] ID_VAL = 32'hA5B0_0016;
`ifdef APB_SLV_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        psel    [2];
    logic        penable [2];
    logic [31:0] paddr   [2];
    logic        pwrite  [2];
    logic [31:0] pwdata  [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    logic        exp_pready  [2];
    logic [31:0] exp_prdata  [2];
    logic        exp_pslverr [2];
    logic [31:0] last_rd     [2];
    logic [31:0] mem [2][NREGS];

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    apb_regfile_slave #(.WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .reset(reset),
        .psel_i(psel[0]), .penable_i(penable[0]), .paddr_i(paddr[0]),
        .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
        .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0])
    );

    apb_regfile_slave #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset),
        .psel_i(psel[1]), .penable_i(penable[1]), .paddr_i(paddr[1]),
        .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
        .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1])
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: address window arithmetic straight from the register map.
    function automatic bit model_hit(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (a >= BASE) && ((o >> 2) < 32'(NREGS));
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) >> 2;
        return int'(o);
    endfunction

    function automatic logic [31:0] model_read(input int u, input logic [31:0] a);
        if (!model_hit(a)) return 32'h0;
        if (model_idx(a) == 0) return ID_VAL;
        return mem[u][model_idx(a)];
    endfunction

    function automatic bit model_err(input logic wr, input logic [31:0] a);
        logic [1:0] lanes;
        lanes = a[1:0];
        return !model_hit(a) || (wr && model_idx(a) == 0)
            || ((a >= BASE + 32'(NREGS * 4)) && (lanes != 2'b00));
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < NREGS; i++)
                mem[u][i] = 32'h0;
    endtask

    task automatic clear_exp(input int u);
        exp_pready[u]  = 1'b0;
        exp_prdata[u]  = 32'h0;
        exp_pslverr[u] = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge: all outputs of both units against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int u = 0; u < 2; u++) begin
                checkOutput($sformatf("u%0d_pready", u), {31'b0, pready[u]}, {31'b0, exp_pready[u]});
                checkOutput($sformatf("u%0d_prdata", u), prdata[u], exp_prdata[u]);
                checkOutput($sformatf("u%0d_pslverr", u), {31'b0, pslverr[u]}, {31'b0, exp_pslverr[u]});
            end
        end
    end

    // One APB transfer on unit u, entered and left just after a rising edge.
    // abort_at / reset_at name the access cycle (0-based) at which psel is
    // dropped or reset is pulsed; -1 disables either.
    task automatic applyStimulus(input int u, input logic [31:0] addr, input logic wr,
                                 input logic [31:0] data, input int abort_at,
                                 input int reset_at);
        int ws;
        logic [31:0] rd_exp;
        bit err_exp;
        ws      = (u == 0) ? 2 : 0;
        rd_exp  = wr ? 32'h0 : model_read(u, addr);
        err_exp = model_err(wr, addr);
        psel[u] = 1'b1; penable[u] = 1'b0; paddr[u] = addr;
        pwrite[u] = wr; pwdata[u] = data;
        clear_exp(u);
        @(posedge clk); #1;
        penable[u] = 1'b1;
        pwdata[u]  = ~data;
        for (int n = 0; n <= ws; n++) begin
            if (n == abort_at) begin
                psel[u] = 1'b0; penable[u] = 1'b0;
                clear_exp(u);
                @(posedge clk); #1;
                return;
            end
            if (n == reset_at) begin
                reset = 1'b1;
                clear_exp(0); clear_exp(1);
                model_reset();
                #1;
                checkOutput("reset_drops_pready", {31'b0, pready[u]}, 32'h0);
                psel[u] = 1'b0; penable[u] = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            exp_pready[u] = (n == ws);
            if (n == ws) begin
                exp_prdata[u]  = rd_exp;
                exp_pslverr[u] = ERR_ON ? err_exp : 1'b0;
                if (!wr) last_rd[u] = prdata[u];
            end
            @(posedge clk); #1;
        end
        if (wr && model_hit(addr) && model_idx(addr) != 0 && !(ERR_ON && err_exp))
            mem[u][model_idx(addr)] = data;
        psel[u] = 1'b0; penable[u] = 1'b0;
        clear_exp(u);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            psel[u] = 1'b0; penable[u] = 1'b0; paddr[u] = 32'h0;
            pwrite[u] = 1'b0; pwdata[u] = 32'h0; last_rd[u] = 32'h0;
            clear_exp(u);
        end
        model_reset();
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // ID register read with two wait states.
        applyStimulus(0, 32'hDEAD_CA00, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_id_read", last_rd[0], 32'hA5B0_0016);
        idle(1);

        // Read / increment / write-back to 0xDEAD_CAFE (register 63).
        applyStimulus(0, 32'hDEAD_CAFE, 1'b1, 32'h0000_0007, -1, -1);
        applyStimulus(0, 32'hDEAD_CAFE, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_read_7", last_rd[0], 32'h0000_0007);
        applyStimulus(0, 32'hDEAD_CAFE, 1'b1, last_rd[0] + 32'd1, -1, -1);
        applyStimulus(0, 32'hDEAD_CAFE, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_read_8", last_rd[0], 32'h0000_0008);
        checkOutput("model_reg63", mem[0][63], 32'h0000_0008);
        idle(2);

        // Zero-wait back-to-back write then read.
        applyStimulus(1, 32'hDEAD_CA04, 1'b1, 32'h1234_5678, -1, -1);
        applyStimulus(1, 32'hDEAD_CA04, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_ws0_read", last_rd[1], 32'h1234_5678);
        // Byte-lane bits ignored for selection.
        applyStimulus(1, 32'hDEAD_CA11, 1'b1, 32'hCAFE_0004, -1, -1);
        applyStimulus(1, 32'hDEAD_CA10, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_lane_ignored", last_rd[1], 32'hCAFE_0004);
        idle(1);

        // Misses and register 0 write.
        applyStimulus(0, 32'hDEAD_CB00, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_miss_read", last_rd[0], 32'h0);
        applyStimulus(0, 32'hDEAD_CA00, 1'b1, 32'h0BAD_0BAD, -1, -1);
        applyStimulus(0, 32'hDEAD_CA00, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_reg0_kept", last_rd[0], 32'hA5B0_0016);
        applyStimulus(1, 32'hDEAD_C9FC, 1'b0, 32'h0, -1, -1);
        applyStimulus(1, 32'hDEAD_CB02, 1'b1, 32'h1111_1111, -1, -1);
        applyStimulus(1, 32'hDEAD_CA08, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_miss_write_dropped", last_rd[1], 32'h0);
        idle(1);

        // Reset during the wait of a write, then during a ready cycle.
        applyStimulus(0, 32'hDEAD_CA08, 1'b1, 32'hFFFF_FFFF, -1, 1);
        idle(1);
        applyStimulus(0, 32'hDEAD_CA08, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_reg2_after_reset", last_rd[0], 32'h0);
        applyStimulus(0, 32'hDEAD_CAFE, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_reg63_cleared", last_rd[0], 32'h0);
        applyStimulus(1, 32'hDEAD_CA04, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_ws0_reg1_cleared", last_rd[1], 32'h0);
        applyStimulus(0, 32'hDEAD_CA00, 1'b0, 32'h0, -1, 2);
        idle(1);

        // Abort mid-access, then a normal transfer right after.
        applyStimulus(0, 32'hDEAD_CA0C, 1'b1, 32'h0000_0055, 1, -1);
        applyStimulus(0, 32'hDEAD_CA0C, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_reg3_after_abort", last_rd[0], 32'h0);
        applyStimulus(0, 32'hDEAD_CA0C, 1'b1, 32'h0000_0033, -1, -1);
        applyStimulus(0, 32'hDEAD_CA0C, 1'b0, 32'h0, -1, -1);
        checkOutput("lit_reg3_new", last_rd[0], 32'h0000_0033);
        idle(3);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
